trace_capture_buffer: RTL and testbench
=======================================

TRACE_CAPTURE_BUFFER -- requirements
Module: trace_capture_buffer

Interface
REQ-001 Parameters SHALL be: DATA_ADDR_WIDTH, default 16, data address width; DATA_DATA_WIDTH, default 32, instruction width; FIFO_DEPTH, default 8 (power of 2), buffer entries; TRACE_ENTRIES, default from shared package, repository capacity.
REQ-002 Ports SHALL be (name direction width meaning):
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- capture_en  in  1  software capture enable.
- lock  in  1  repository in replay mode; no captures accepted.
- in_valid  in  1  tracer presents an entry this cycle; there is no stall path back to the tracer.
- in_mem_addr  in  DATA_ADDR_WIDTH  data address of the traced instruction.
- in_instruction  in  DATA_DATA_WIDTH  traced instruction word.
- trace_out  out  trace_format  entry forwarded to the repository.
- trace_capture_enable  out  1  registered copy of capture_en.
- trace_ready  out  1  one-cycle strobe; trace_out is valid this cycle.
- overflow  out  1  sticky; an entry was dropped because the FIFO was full.
- repo_full  out  1  sticky; TRACE_ENTRIES entries have been forwarded.
- forwarded_count  out  $clog2(TRACE_ENTRIES)+1  entries forwarded since reset.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.

Function
REQ-003 The FSM SHALL have four states: IDLE, CAPTURE, HOLD, SATURATED.
REQ-004 Transitions SHALL be:
- IDLE->CAPTURE when capture_en=1 and lock=0.
- CAPTURE->HOLD when lock=1; HOLD->CAPTURE when lock=0.
- CAPTURE->IDLE when capture_en=0 and the FIFO is empty.
- CAPTURE->SATURATED when forwarded_count reaches TRACE_ENTRIES.
- SATURATED is exited only by reset.
REQ-005 Push: in CAPTURE or HOLD, in_valid=1 with the FIFO not full SHALL write {in_mem_addr, in_instruction} at the write pointer and increment it, wrapping modulo FIFO_DEPTH.
REQ-006 Drop: in_valid=1 with the FIFO full in CAPTURE or HOLD SHALL discard the entry and set overflow.
REQ-007 In IDLE and SATURATED, in_valid entries SHALL be discarded silently; overflow is not set.
REQ-008 Pop: in CAPTURE only, with the FIFO non-empty, exactly one entry per cycle SHALL be registered onto trace_out with trace_ready=1 for one cycle.
REQ-009 The repository has no backpressure, so a pop SHALL always complete.
REQ-010 Latency: an entry pushed in cycle N into an empty FIFO SHALL appear with trace_ready in cycle N+2 (one cycle to write, one cycle for the registered output).
REQ-011 Full detection: fullness is taken from the start-of-cycle occupancy, so a pop in the same cycle does not free a slot for a push in that cycle.
REQ-012 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave fifo_level unchanged.
REQ-013 trace_ready SHALL be 0 in IDLE, HOLD and SATURATED; in HOLD the FIFO contents are retained.
REQ-014 On entering HOLD, trace_out SHALL hold its last value; no entry is lost or duplicated across lock toggles.
REQ-015 forwarded_count SHALL increment on each trace_ready and saturate at TRACE_ENTRIES.
REQ-016 repo_full SHALL set in the cycle that forwarded_count becomes TRACE_ENTRIES.
REQ-017 On entering SATURATED the FIFO SHALL be flushed (read and write pointers equal, fifo_level=0).
REQ-018 trace_capture_enable SHALL equal capture_en delayed by one cycle.

Reset
REQ-019 While rst_n=0 at posedge clk, the block SHALL reset to:
- state=IDLE; pointers=0; fifo_level=0.
- trace_ready=0, trace_capture_enable=0, overflow=0, repo_full=0, forwarded_count=0.
- trace_out all zeros.
REQ-020 Reset asserted mid-operation SHALL discard all buffered entries with no trace_ready strobe in the following cycle.

Configuration
REQ-021 Macro TRACE_MEM_FILTER_EN, when defined, SHALL push only entries whose in_instruction[6:0] is 7'b0000011 (load) or 7'b0100011 (store).
REQ-022 With TRACE_MEM_FILTER_EN defined, other entries SHALL be discarded without setting overflow.
REQ-023 With TRACE_MEM_FILTER_EN undefined, every in_valid entry SHALL be eligible for push.

Structure
REQ-024 trace_format SHALL be reused from gouram_datatypes.
REQ-025 The state enum and the load/store opcode constants SHALL live in package trace_capture_datatypes.
REQ-026 FIFO storage and pointers SHALL be a sub-module sync_fifo (parameters WIDTH, DEPTH; ports push, pop, full, empty, level).

Verification
REQ-027 The bench SHALL cover at least these directed scenarios:
- Single entry: capture_en=1, push {0x0040, 0x00052083} -> trace_ready one cycle, trace_out equal to it, 2 cycles after push; forwarded_count=1.
- Lock hold: push 5 entries, assert lock after 2 pops -> 3 entries retained, no strobes; release lock -> remaining 3 emitted in order.
- Overflow: lock=1, push 9 entries with FIFO_DEPTH=8 -> fifo_level=8, overflow=1; after unlock exactly 8 entries emitted.
- Saturation: TRACE_ENTRIES=16, stream 20 entries -> exactly 16 strobes, repo_full=1, state SATURATED, further inputs ignored.
- Filter: TRACE_MEM_FILTER_EN defined, push add 0x00B50533 then lw 0x0002A303 -> only the lw forwarded; overflow=0.
- Reset mid-stream: 4 entries buffered, rst_n=0 -> fifo_level=0, all outputs zero, no strobe afterwards.

Source files
------------

// File: rtl/gouram_datatypes_pkg.sv
// Shared trace types used across the gouram tracing blocks.
package gouram_datatypes;

  localparam int TRACE_ADDR_WIDTH   = 16;
  localparam int TRACE_DATA_WIDTH   = 32;
  localparam int TRACE_REPO_ENTRIES = 64;

  typedef struct packed {
    logic [TRACE_ADDR_WIDTH-1:0] mem_addr;
    logic [TRACE_DATA_WIDTH-1:0] instruction;
  } trace_format;

endpackage

// File: rtl/trace_capture_buffer_pkg.sv
// Capture-buffer FSM states and the RISC-V load/store opcodes used by the optional
// memory-access filter.
package trace_capture_datatypes;

  typedef enum logic [1:0] {
    TC_IDLE      = 2'd0,
    TC_CAPTURE   = 2'd1,
    TC_HOLD      = 2'd2,
    TC_SATURATED = 2'd3
  } tc_state_e;

  localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE = 7'b0100011;

  function automatic logic is_mem_access(input logic [6:0] opcode);
    return (opcode == OPCODE_LOAD) || (opcode == OPCODE_STORE);
  endfunction

endpackage

// File: rtl/trace_capture_buffer_sync_fifo.sv
// Power-of-two synchronous FIFO with a flush input; rdata shows the head entry
// combinationally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_push, do_pop;

  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/trace_capture_buffer.sv
// Buffers tracer entries and forwards them one per cycle to the trace repository.
// Define TRACE_MEM_FILTER_EN to capture only load/store instructions.
module trace_capture_buffer
  import gouram_datatypes::*;
  import trace_capture_datatypes::*;
#(
  parameter int DATA_ADDR_WIDTH = 16,
  parameter int DATA_DATA_WIDTH = 32,
  parameter int FIFO_DEPTH      = 8,
  parameter int TRACE_ENTRIES   = TRACE_REPO_ENTRIES
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               capture_en,
  input  logic                               lock,
  input  logic                               in_valid,
  input  logic [DATA_ADDR_WIDTH-1:0]         in_mem_addr,
  input  logic [DATA_DATA_WIDTH-1:0]         in_instruction,
  output trace_format                        trace_out,
  output logic                               trace_capture_enable,
  output logic                               trace_ready,
  output logic                               overflow,
  output logic                               repo_full,
  output logic [$clog2(TRACE_ENTRIES):0]     forwarded_count,
  output logic [$clog2(FIFO_DEPTH):0]        fifo_level,
  output tc_state_e                          state_o
);

  localparam int CNT_W   = $clog2(TRACE_ENTRIES) + 1;
  localparam int LVL_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int ENTRY_W = $bits(trace_format);

  tc_state_e        state_q, state_d;
  trace_format      trace_out_q, push_entry, pop_entry;
  logic             trace_ready_q, overflow_q, repo_full_q, capture_en_q;
  logic [CNT_W-1:0] count_q, count_inc;
  logic             fifo_full, fifo_empty;
  logic [LVL_W-1:0] fifo_level_w;
  logic             eligible, accepting, sat_reached, flush, push, pop, drop;

  // The tracer cannot be stalled, so an entry either lands in the FIFO or is lost.
`ifdef TRACE_MEM_FILTER_EN
  assign eligible = in_valid && is_mem_access(in_instruction[6:0]);
`else
  assign eligible = in_valid;
`endif

  always_comb begin
    push_entry             = '0;
    push_entry.mem_addr    = TRACE_ADDR_WIDTH'(in_mem_addr);
    push_entry.instruction = TRACE_DATA_WIDTH'(in_instruction);
  end

  assign accepting   = (state_q == TC_CAPTURE) || (state_q == TC_HOLD);
  assign sat_reached = (count_q == CNT_W'(TRACE_ENTRIES));
  assign count_inc   = count_q + CNT_W'(1);
  assign flush       = (state_q != TC_SATURATED) && (state_d == TC_SATURATED);
  assign push        = accepting && eligible && !fifo_full && !flush;
  assign drop        = accepting && eligible && fifo_full;
  // Popping is suppressed while lock is high so the strobe never lands in HOLD.
  assign pop         = (state_q == TC_CAPTURE) && !lock && !fifo_empty && !sat_reached;

  always_comb begin
    state_d = state_q;
    case (state_q)
      TC_IDLE:      if (capture_en && !lock) state_d = TC_CAPTURE;
      TC_CAPTURE: begin
        if (sat_reached)                   state_d = TC_SATURATED;
        else if (lock)                     state_d = TC_HOLD;
        else if (!capture_en && fifo_empty) state_d = TC_IDLE;
      end
      TC_HOLD:      if (!lock) state_d = TC_CAPTURE;
      default:      state_d = TC_SATURATED;
    endcase
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (pop_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level_w)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= TC_IDLE;
      trace_out_q   <= '0;
      trace_ready_q <= 1'b0;
      overflow_q    <= 1'b0;
      repo_full_q   <= 1'b0;
      capture_en_q  <= 1'b0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      trace_ready_q <= pop;
      capture_en_q  <= capture_en;
      if (drop) overflow_q <= 1'b1;
      if (pop) begin
        trace_out_q <= pop_entry;
        count_q     <= count_inc;
        if (count_inc == CNT_W'(TRACE_ENTRIES)) repo_full_q <= 1'b1;
      end
    end
  end

  assign trace_out            = trace_out_q;
  assign trace_ready          = trace_ready_q;
  assign overflow             = overflow_q;
  assign repo_full            = repo_full_q;
  assign trace_capture_enable = capture_en_q;
  assign forwarded_count      = count_q;
  assign fifo_level           = fifo_level_w;
  assign state_o              = state_q;

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Directed bench for trace_capture_buffer with a queue-based reference model checked every cycle.
module tb_trace_capture_buffer;
  import gouram_datatypes::*;
  import trace_capture_datatypes::*;

  localparam int DEPTH = 8;
  localparam int TE    = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        capture_en = 1'b0;
  logic        lock = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_mem_addr = '0;
  logic [31:0] in_instruction = '0;
  trace_format trace_out;
  logic        trace_capture_enable, trace_ready, overflow, repo_full;
  logic [4:0]  forwarded_count;
  logic [3:0]  fifo_level;
  tc_state_e   state_o;

  trace_capture_buffer #(
    .DATA_ADDR_WIDTH (16),
    .DATA_DATA_WIDTH (32),
    .FIFO_DEPTH      (DEPTH),
    .TRACE_ENTRIES   (TE)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .capture_en           (capture_en),
    .lock                 (lock),
    .in_valid             (in_valid),
    .in_mem_addr          (in_mem_addr),
    .in_instruction       (in_instruction),
    .trace_out            (trace_out),
    .trace_capture_enable (trace_capture_enable),
    .trace_ready          (trace_ready),
    .overflow             (overflow),
    .repo_full            (repo_full),
    .forwarded_count      (forwarded_count),
    .fifo_level           (fifo_level),
    .state_o              (state_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int strobe_cnt = 0;
  logic [47:0] got_q[$];
  bit check_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: the buffer as a queue plus the mode rules, stepped once per clock.
  logic [47:0] m_q[$];
  tc_state_e   m_st = TC_IDLE;
  logic [47:0] m_out = '0;
  logic        m_ready = 1'b0, m_ovf = 1'b0, m_full = 1'b0, m_tce = 1'b0;
  int          m_cnt = 0;

  always @(posedge clk) begin : model
    bit elig, accept, was_full, do_pop, do_flush;
    tc_state_e nxt;
    if (!rst_n) begin
      m_q.delete();
      m_st = TC_IDLE; m_out = '0; m_ready = 0; m_ovf = 0; m_full = 0; m_tce = 0; m_cnt = 0;
    end else begin
`ifdef TRACE_MEM_FILTER_EN
      elig = in_valid && (in_instruction[6:0] == 7'b0000011 || in_instruction[6:0] == 7'b0100011);
`else
      elig = in_valid;
`endif
      accept   = (m_st == TC_CAPTURE) || (m_st == TC_HOLD);
      was_full = (m_q.size() == DEPTH);
      do_pop   = (m_st == TC_CAPTURE) && !lock && (m_q.size() > 0) && (m_cnt < TE);
      nxt = m_st;
      case (m_st)
        TC_IDLE:    if (capture_en && !lock) nxt = TC_CAPTURE;
        TC_CAPTURE: if (m_cnt == TE) nxt = TC_SATURATED;
                    else if (lock) nxt = TC_HOLD;
                    else if (!capture_en && m_q.size() == 0) nxt = TC_IDLE;
        TC_HOLD:    if (!lock) nxt = TC_CAPTURE;
        default:    nxt = TC_SATURATED;
      endcase
      do_flush = (nxt == TC_SATURATED) && (m_st != TC_SATURATED);
      m_ready = 0;
      if (do_pop) begin
        m_out = m_q.pop_front();
        m_ready = 1;
        m_cnt++;
        if (m_cnt == TE) m_full = 1;
      end
      if (accept && elig) begin
        if (was_full) m_ovf = 1;
        else m_q.push_back({in_mem_addr, in_instruction});
      end
      if (do_flush) m_q.delete();
      m_tce = capture_en;
      m_st = nxt;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("ready", 64'(trace_ready), 64'(m_ready));
      check("trace_out", 64'(trace_out), 64'(m_out));
      check("fifo_level", 64'(fifo_level), 64'(m_q.size()));
      check("overflow", 64'(overflow), 64'(m_ovf));
      check("repo_full", 64'(repo_full), 64'(m_full));
      check("fwd_count", 64'(forwarded_count), 64'(m_cnt));
      check("capture_enable", 64'(trace_capture_enable), 64'(m_tce));
      check("state", 64'(state_o), 64'(m_st));
      if (trace_ready === 1'b1) begin
        strobe_cnt++;
        got_q.push_back(trace_out);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0; capture_en = 0; lock = 0; in_valid = 0;
    tick(2);
    rst_n = 1;
    strobe_cnt = 0;
    got_q.delete();
  endtask

  function automatic logic [47:0] ent(input int i);
    logic [15:0] a;
    logic [31:0] d;
    a = 16'h0100 + 16'(4 * i);
    d = (32'(i) << 20) | 32'h3;
    return {a, d};
  endfunction

  task automatic drive(input logic [47:0] e);
    in_valid = 1;
    {in_mem_addr, in_instruction} = e;
  endtask

  task automatic check_order(input string name, input int n);
    check({name, "_count"}, 64'(got_q.size()), 64'(n));
    for (int i = 0; i < n && i < got_q.size(); i++)
      check(name, 64'(got_q[i]), 64'(ent(i)));
  endtask

  initial begin
    do_reset();
    check_en = 1;
    check("reset_state", 64'(state_o), 64'(TC_IDLE));
    check("reset_level", 64'(fifo_level), 64'd0);

    // Single entry: strobe two edges after the push edge.
    capture_en = 1; tick();
    drive({16'h0040, 32'h00052083}); tick();
    in_valid = 0;
    check("single_no_early", 64'(trace_ready), 64'd0);
    tick();
    check("single_ready", 64'(trace_ready), 64'd1);
    check("single_out", 64'(trace_out), 64'h0040_0005_2083);
    check("single_count", 64'(forwarded_count), 64'd1);
    tick();
    check("single_strobes", 64'(strobe_cnt), 64'd1);

    // Lock hold: lock seen after two pops retains three entries.
    do_reset();
    capture_en = 1; tick();
    for (int k = 0; k < 5; k++) begin
      if (k == 3) lock = 1;
      drive(ent(k)); tick();
    end
    in_valid = 0; tick(3);
    check("hold_level", 64'(fifo_level), 64'd3);
    check("hold_strobes", 64'(strobe_cnt), 64'd2);
    check("hold_state", 64'(state_o), 64'(TC_HOLD));
    check("hold_out", 64'(trace_out), 64'(ent(1)));
    lock = 0; tick(6);
    check("hold_total", 64'(strobe_cnt), 64'd5);
    check_order("hold_order", 5);

    // Overflow: nine pushes into a locked, depth-8 buffer.
    do_reset();
    capture_en = 1; tick();
    lock = 1; tick();
    for (int k = 0; k < 9; k++) begin
      drive(ent(k)); tick();
    end
    in_valid = 0;
    check("ovf_level", 64'(fifo_level), 64'd8);
    check("ovf_flag", 64'(overflow), 64'd1);
    lock = 0; tick(12);
    check("ovf_strobes", 64'(strobe_cnt), 64'd8);
    check_order("ovf_order", 8);
    check("ovf_sticky", 64'(overflow), 64'd1);

    // Filter: add then lw.
    do_reset();
    capture_en = 1; tick();
    drive({16'h0010, 32'h00B50533}); tick();
    drive({16'h0014, 32'h0002A303}); tick();
    in_valid = 0; tick(4);
`ifdef TRACE_MEM_FILTER_EN
    check("filter_strobes", 64'(strobe_cnt), 64'd1);
    check("filter_out", 64'(got_q.size() > 0 ? got_q[0] : 48'h0), 64'h0014_0002_A303);
`else
    check("nofilter_strobes", 64'(strobe_cnt), 64'd2);
    check("nofilter_out", 64'(got_q.size() > 1 ? got_q[1] : 48'h0), 64'h0014_0002_A303);
`endif
    check("filter_ovf", 64'(overflow), 64'd0);

    // Reset mid-stream with four entries buffered.
    do_reset();
    capture_en = 1; tick();
    drive(ent(0)); tick();
    in_valid = 0; tick(2);
    lock = 1; tick();
    for (int k = 1; k < 5; k++) begin
      drive(ent(k)); tick();
    end
    in_valid = 0;
    check("rst_pre_level", 64'(fifo_level), 64'd4);
    rst_n = 0; tick();
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_out", 64'(trace_out), 64'd0);
    check("rst_count", 64'(forwarded_count), 64'd0);
    check("rst_tce", 64'(trace_capture_enable), 64'd0);
    check("rst_state", 64'(state_o), 64'(TC_IDLE));
    rst_n = 1; capture_en = 0; lock = 0; strobe_cnt = 0;
    tick(4);
    check("rst_no_strobe", 64'(strobe_cnt), 64'd0);

    // Saturation: 20 entries offered, 16 forwarded.
    do_reset();
    capture_en = 1; tick();
    for (int k = 0; k < 20; k++) begin
      drive(ent(k)); tick();
    end
    in_valid = 0; tick(3);
    check("sat_strobes", 64'(strobe_cnt), 64'd16);
    check("sat_full", 64'(repo_full), 64'd1);
    check("sat_count", 64'(forwarded_count), 64'd16);
    check("sat_state", 64'(state_o), 64'(TC_SATURATED));
    check("sat_level", 64'(fifo_level), 64'd0);
    check_order("sat_order", 16);
    for (int k = 0; k < 3; k++) begin
      drive(ent(30 + k)); tick();
    end
    in_valid = 0; capture_en = 0; tick(3);
    check("sat_ignore_level", 64'(fifo_level), 64'd0);
    check("sat_ignore_strobes", 64'(strobe_cnt), 64'd16);
    check("sat_stays", 64'(state_o), 64'(TC_SATURATED));
    check("sat_no_ovf", 64'(overflow), 64'd0);

    check_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
